// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample depacketizer and its sample RAM.
package audio_pkg;

    localparam int AUDIO_BIT_WIDTH    = 16;
    localparam int AUDIO_CHANNELS     = 2;
    localparam int MAX_PACKET_SAMPLES = 4;

    typedef logic [AUDIO_CHANNELS-1:0][AUDIO_BIT_WIDTH-1:0] sample_t;

    typedef enum logic {
        FILL = 1'b0,
        PLAY = 1'b1
    } playback_state_t;

    // Packet decoders may report 5..7; anything above a full packet counts as a full packet.
    function automatic logic [2:0] clamp_count(input logic [2:0] count);
        return (count > 3'(MAX_PACKET_SAMPLES)) ? 3'(MAX_PACKET_SAMPLES) : count;
    endfunction

endpackage

// File: rtl/audio_sample_ram.sv
// Sample store: several independent write lanes, one registered read port that holds when idle.
module audio_sample_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic [LANES-1:0]            wr_en,
    input  logic [LANES-1:0][AW-1:0]    wr_addr,
    input  logic [LANES-1:0][WIDTH-1:0] wr_data,
    input  logic                        rd_en,
    input  logic [AW-1:0]               rd_addr,
    output logic [WIDTH-1:0]            rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Lane addresses are always distinct (consecutive slots), so write order does not matter.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                mem[wr_addr[i]] <= wr_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/audio_sample_depacketizer.sv
// Circular sample buffer fed by packets of up to four samples, drained one sample per audio strobe
// after pre-filling to a threshold.
module audio_sample_depacketizer
    import audio_pkg::*;
#(
    parameter int BUFFER_SIZE     = 128,
    parameter int BIT_WIDTH       = AUDIO_BIT_WIDTH,
    parameter int CHANNELS        = AUDIO_CHANNELS,
    parameter int PARALLEL_IN     = MAX_PACKET_SAMPLES,
    parameter int START_THRESHOLD = 64
) (
    input  logic                                            clk_pixel,
    input  logic                                            reset,
    input  logic                                            packet_valid,
    input  logic [2:0]                                      sample_count,
    input  logic [PARALLEL_IN-1:0][CHANNELS-1:0][BIT_WIDTH-1:0] audio_in,
    input  logic                                            sample_strobe,
    output logic [CHANNELS-1:0][BIT_WIDTH-1:0]              audio_out,
    output logic                                            audio_out_valid,
    output logic [$clog2(BUFFER_SIZE):0]                    level,
    output logic                                            playing,
    output logic                                            overflow,
    output logic                                            underrun
);

    localparam int AW = $clog2(BUFFER_SIZE);
    localparam int LW = AW + 1;
    localparam int SW = CHANNELS * BIT_WIDTH;

    logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]           level_reg, level_next;
    playback_state_t         state_reg, state_next;
    logic                    valid_reg, overflow_reg, underrun_reg;

    logic [2:0]              n_req, n_acc;
    logic                    rd_fire, accept, strobe_empty;
    logic [LW+1:0]           room_sum;
    logic [PARALLEL_IN-1:0]  wr_en;
    logic [PARALLEL_IN-1:0][AW-1:0] wr_addr;
    logic [SW-1:0]           rd_data;

    always_comb begin
        n_req        = packet_valid ? clamp_count(sample_count) : 3'd0;
        rd_fire      = sample_strobe && (state_reg == PLAY) && (level_reg != '0);
        strobe_empty = sample_strobe && (state_reg == PLAY) && (level_reg == '0);
        // The same-cycle read frees a slot before the write is judged, so full+read+write is legal.
        room_sum     = {2'b00, level_reg} - (LW+2)'(rd_fire) + (LW+2)'(n_req);
        accept       = (n_req != 3'd0) && (room_sum <= (LW+2)'(BUFFER_SIZE));
        n_acc        = accept ? n_req : 3'd0;
        level_next   = level_reg + LW'(n_acc) - LW'(rd_fire);
    end

    generate
        for (genvar gi = 0; gi < PARALLEL_IN; gi++) begin : g_lane
            assign wr_en[gi]   = accept && (n_req > 3'(gi));
            assign wr_addr[gi] = wr_ptr_reg + AW'(gi);
        end
    endgenerate

    audio_sample_ram #(
        .DEPTH (BUFFER_SIZE),
        .WIDTH (SW),
        .LANES (PARALLEL_IN),
        .AW    (AW)
    ) u_ram (
        .clk     (clk_pixel),
        .srst    (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (audio_in),
        .rd_en   (rd_fire),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_reg + AW'(n_acc);
            rd_ptr_reg   <= rd_ptr_reg + AW'(rd_fire);
            level_reg    <= level_next;
            valid_reg    <= rd_fire;
            overflow_reg <= (n_req != 3'd0) && !accept;
            underrun_reg <= strobe_empty;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL:    if (level_reg >= LW'(START_THRESHOLD)) state_next = PLAY;
            PLAY:    if (strobe_empty) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        playing = (state_reg == PLAY);
    end

    assign audio_out       = rd_data;
    assign audio_out_valid = valid_reg;
    assign level           = level_reg;
    assign overflow        = overflow_reg;
    assign underrun        = underrun_reg;

endmodule

// File: tb/tb_audio_sample_depacketizer.sv
// Directed bench: stimulus pushes expected output samples into a queue, a negedge monitor checks them.
module tb_audio_sample_depacketizer;
    import audio_pkg::*;

    logic                 clk_pixel = 1'b0;
    logic                 reset;
    logic                 packet_valid;
    logic [2:0]           sample_count;
    logic [3:0][1:0][15:0] audio_in;
    logic                 sample_strobe;
    logic [1:0][15:0]     audio_out;
    logic                 audio_out_valid;
    logic [7:0]           level;
    logic                 playing;
    logic                 overflow;
    logic                 underrun;

    int errors = 0;
    int checks = 0;
    int ovf_cnt = 0;
    int und_cnt = 0;
    sample_t exp_q[$];

    audio_sample_depacketizer dut (
        .clk_pixel       (clk_pixel),
        .reset           (reset),
        .packet_valid    (packet_valid),
        .sample_count    (sample_count),
        .audio_in        (audio_in),
        .sample_strobe   (sample_strobe),
        .audio_out       (audio_out),
        .audio_out_valid (audio_out_valid),
        .level           (level),
        .playing         (playing),
        .overflow        (overflow),
        .underrun        (underrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    function automatic sample_t mk(input int idx);
        logic [15:0] v;
        v = 16'(idx);
        return {16'h8000 + v, v};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic drive(input int cnt, input int base, input bit strobe, input bit valid);
        packet_valid  = valid;
        sample_count  = 3'(cnt);
        for (int k = 0; k < 4; k++) audio_in[k] = mk(base + k);
        sample_strobe = strobe;
        tick();
        packet_valid  = 1'b0;
        sample_count  = 3'd0;
        sample_strobe = 1'b0;
    endtask

    task automatic strobe_n(input int n);
        sample_strobe = 1'b1;
        repeat (n) tick();
        sample_strobe = 1'b0;
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk_pixel) begin
        if (overflow) ovf_cnt++;
        if (underrun) und_cnt++;
        if (audio_out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sample_out: got %0h expected no output", audio_out);
            end else begin
                sample_t e;
                e = exp_q.pop_front();
                if (audio_out !== e) begin
                    errors++;
                    $display("FAIL sample_out: got %0h expected %0h", audio_out, e);
                end else begin
                    $display("ok   sample_out: %0h", audio_out);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; packet_valid = 1'b0; sample_count = 3'd0;
        audio_in = '0; sample_strobe = 1'b0;
        repeat (3) tick();
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_playing", 64'(playing), 64'd0);
        chk("reset_audio_out", 64'(audio_out), 64'd0);
        chk("reset_pulses", 64'({audio_out_valid, overflow, underrun}), 64'd0);
        reset = 1'b0;
        tick();

        // Pre-fill to threshold, PLAY two cycles after the last packet
        for (int p = 0; p < 16; p++) drive(4, p * 4, 1'b0, 1'b1);
        chk("fill_level", 64'(level), 64'd64);
        chk("fill_not_yet_playing", 64'(playing), 64'd0);
        tick();
        chk("fill_playing", 64'(playing), 64'd1);

        // Drain in order, then underrun on an empty buffer
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(mk(i));
            sample_strobe = 1'b1;
            tick();
            sample_strobe = 1'b0;
            if (i == 0) chk("first_valid_latency", 64'(audio_out_valid), 64'd1);
            repeat (7) tick();
        end
        chk("drained_level", 64'(level), 64'd0);
        chk("drained_playing", 64'(playing), 64'd1);
        strobe_n(1);
        chk("underrun_pulse", 64'(underrun), 64'd1);
        chk("underrun_to_fill", 64'(playing), 64'd0);
        chk("underrun_hold_out", 64'(audio_out), 64'(mk(63)));
        chk("underrun_no_valid", 64'(audio_out_valid), 64'd0);
        tick();

        // Overflow boundaries around a full buffer
        for (int p = 0; p < 31; p++) drive(4, 100 + p * 4, 1'b0, 1'b1);
        drive(2, 224, 1'b0, 1'b1);
        chk("near_full_level", 64'(level), 64'd126);
        drive(4, 900, 1'b0, 1'b1);
        chk("ovf_pulse", 64'(overflow), 64'd1);
        chk("ovf_level_kept", 64'(level), 64'd126);
        drive(2, 226, 1'b0, 1'b1);
        chk("fill_to_full_no_ovf", 64'(overflow), 64'd0);
        chk("full_level", 64'(level), 64'd128);
        exp_q.push_back(mk(100));
        drive(4, 910, 1'b1, 1'b1);
        chk("ovf_with_read_pulse", 64'(overflow), 64'd1);
        chk("ovf_with_read_level", 64'(level), 64'd127);
        exp_q.push_back(mk(101));
        drive(2, 228, 1'b1, 1'b1);
        chk("read_write_to_full_no_ovf", 64'(overflow), 64'd0);
        chk("read_write_full_level", 64'(level), 64'd128);
        for (int v = 102; v < 230; v++) exp_q.push_back(mk(v));
        strobe_n(128);
        chk("full_drain_level", 64'(level), 64'd0);
        chk("full_drain_playing", 64'(playing), 64'd1);

        // Move the write pointer to 126, then straddle the wrap
        for (int p = 0; p < 15; p++) drive(4, 300 + p * 4, 1'b0, 1'b1);
        for (int v = 300; v < 360; v++) exp_q.push_back(mk(v));
        strobe_n(60);
        drive(4, 400, 1'b0, 1'b1);
        drive(2, 404, 1'b0, 1'b1);
        chk("wrap_level", 64'(level), 64'd6);
        for (int v = 400; v < 406; v++) exp_q.push_back(mk(v));
        strobe_n(6);
        chk("wrap_drain_level", 64'(level), 64'd0);

        // Same-cycle packet and read at level 1, count clamping, empty packets
        drive(1, 500, 1'b0, 1'b1);
        exp_q.push_back(mk(500));
        drive(7, 501, 1'b1, 1'b1);
        chk("clamp7_level", 64'(level), 64'd4);
        chk("clamp7_no_ovf", 64'(overflow), 64'd0);
        drive(0, 700, 1'b0, 1'b1);
        chk("count0_level", 64'(level), 64'd4);
        chk("count0_no_ovf", 64'(overflow), 64'd0);
        drive(4, 710, 1'b0, 1'b0);
        chk("invalid_packet_level", 64'(level), 64'd4);
        for (int v = 501; v < 505; v++) exp_q.push_back(mk(v));
        strobe_n(4);
        chk("clamp_drain_level", 64'(level), 64'd0);

        // Reset wins over a same-cycle packet and strobe
        drive(4, 600, 1'b0, 1'b1);
        chk("pre_reset_level", 64'(level), 64'd4);
        reset = 1'b1;
        drive(4, 610, 1'b1, 1'b1);
        chk("midreset_level", 64'(level), 64'd0);
        chk("midreset_playing", 64'(playing), 64'd0);
        chk("midreset_audio_out", 64'(audio_out), 64'd0);
        chk("midreset_pulses", 64'({audio_out_valid, overflow, underrun}), 64'd0);
        reset = 1'b0;
        tick();

        chk("overflow_pulse_count", 64'(ovf_cnt), 64'd2);
        chk("underrun_pulse_count", 64'(und_cnt), 64'd1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
